// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - RV32I(+M) decode stage with output register and 1-entry skid buffer
module decode_stage #(
    parameter bit EN_MEXT = 1'b0,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_inst,
    input  logic [31:0]      in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_pc,
    output logic [4:0]       rs1,
    output logic [4:0]       rs2,
    output logic [4:0]       rd,
    output logic [3:0]       alu_ctrl,
    output logic [2:0]       branch,
    output logic [3:0]       ls_type,
    output logic [2:0]       sext_type,
    output logic [1:0]       wb_ctrl,
    output logic             jump,
    output logic             jump_type,
    output logic             alu_src1,
    output logic             alu_src2,
    output logic             we_reg,
    output logic             we_mem,
    output logic [2:0]       mul_op,
    output logic             mul_valid,
    output logic             illegal,
    output logic [CNT_W-1:0] dec_count
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLL  = 4'b0101;
    localparam logic [3:0] ALU_SLT  = 4'b0110;
    localparam logic [3:0] ALU_SLTU = 4'b0111;
    localparam logic [3:0] ALU_SRL  = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1001;
    localparam logic [3:0] ALU_NOP  = 4'b1110;

    localparam logic [3:0] LS_NONE = 4'b1111;
    localparam logic [2:0] BR_NONE = 3'b010;

    localparam logic [2:0] SX_I   = 3'b000;
    localparam logic [2:0] SX_B   = 3'b001;
    localparam logic [2:0] SX_JAL = 3'b010;
    localparam logic [2:0] SX_U   = 3'b011;
    localparam logic [2:0] SX_S   = 3'b110;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MUL  = 7'b0000001;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [3:0]  alu_ctrl;
        logic [2:0]  branch;
        logic [3:0]  ls_type;
        logic [2:0]  sext_type;
        logic [1:0]  wb_ctrl;
        logic        jump;
        logic        jump_type;
        logic        alu_src1;
        logic        alu_src2;
        logic        we_reg;
        logic        we_mem;
        logic [2:0]  mul_op;
        logic        mul_valid;
        logic        illegal;
    } dec_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    // Bubble encoding: used as the reset value and as the decode starting point
    function automatic dec_t nop_dec();
        dec_t d;
        d           = '0;
        d.alu_ctrl  = ALU_NOP;
        d.branch    = BR_NONE;
        d.ls_type   = LS_NONE;
        return d;
    endfunction

    state_t           state_q, state_d;
    dec_t             out_q, out_d;
    dec_t             skid_q, skid_d;
    dec_t             dec;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             accept;
    logic             out_hs;
    logic             load_out_in;
    logic             load_out_skid;
    logic             load_skid;

    logic [6:0]       opcode;
    logic [2:0]       funct3;
    logic [6:0]       funct7;

    assign opcode = in_inst[6:0];
    assign funct3 = in_inst[14:12];
    assign funct7 = in_inst[31:25];

    // Combinational decode of the incoming instruction word
    always_comb begin
        dec    = nop_dec();
        dec.pc = in_pc;
        if (in_inst != 32'd0) begin
            case (opcode)
                OP_R: begin
                    dec.rs1    = in_inst[19:15];
                    dec.rs2    = in_inst[24:20];
                    dec.rd     = in_inst[11:7];
                    dec.we_reg = 1'b1;
                    if (funct7 == F7_BASE) begin
                        case (funct3)
                            3'b000:  dec.alu_ctrl = ALU_ADD;
                            3'b001:  dec.alu_ctrl = ALU_SLL;
                            3'b010:  dec.alu_ctrl = ALU_SLT;
                            3'b011:  dec.alu_ctrl = ALU_SLTU;
                            3'b100:  dec.alu_ctrl = ALU_XOR;
                            3'b101:  dec.alu_ctrl = ALU_SRL;
                            3'b110:  dec.alu_ctrl = ALU_OR;
                            default: dec.alu_ctrl = ALU_AND;
                        endcase
                    end else if (funct7 == F7_ALT) begin
                        if (funct3 == 3'b000) begin
                            dec.alu_ctrl = ALU_SUB;
                        end else if (funct3 == 3'b101) begin
                            dec.alu_ctrl = ALU_SRA;
                        end else begin
                            dec.illegal = 1'b1;
                        end
                    end else if (EN_MEXT && funct7 == F7_MUL) begin
                        dec.mul_valid = 1'b1;
                        dec.mul_op    = funct3;
                        dec.alu_ctrl  = ALU_NOP;
                    end else begin
                        dec.illegal = 1'b1;
                    end
                end
                OP_I: begin
                    dec.rs1       = in_inst[19:15];
                    dec.rd        = in_inst[11:7];
                    dec.alu_src2  = 1'b1;
                    dec.sext_type = SX_I;
                    dec.we_reg    = 1'b1;
                    case (funct3)
                        3'b000: dec.alu_ctrl = ALU_ADD;
                        3'b010: dec.alu_ctrl = ALU_SLT;
                        3'b011: dec.alu_ctrl = ALU_SLTU;
                        3'b100: dec.alu_ctrl = ALU_XOR;
                        3'b110: dec.alu_ctrl = ALU_OR;
                        3'b111: dec.alu_ctrl = ALU_AND;
                        3'b001: begin
                            dec.alu_ctrl = ALU_SLL;
                            dec.illegal  = (funct7 != F7_BASE);
                        end
                        default: begin
                            if (funct7 == F7_BASE) begin
                                dec.alu_ctrl = ALU_SRL;
                            end else if (funct7 == F7_ALT) begin
                                dec.alu_ctrl = ALU_SRA;
                            end else begin
                                dec.illegal = 1'b1;
                            end
                        end
                    endcase
                end
                OP_LOAD: begin
                    dec.rs1       = in_inst[19:15];
                    dec.rd        = in_inst[11:7];
                    dec.alu_ctrl  = ALU_ADD;
                    dec.alu_src2  = 1'b1;
                    dec.sext_type = SX_I;
                    dec.wb_ctrl   = 2'b01;
                    dec.we_reg    = 1'b1;
                    case (funct3)
                        3'b000:  dec.ls_type = 4'b0000;
                        3'b001:  dec.ls_type = 4'b0010;
                        3'b010:  dec.ls_type = 4'b0100;
                        3'b100:  dec.ls_type = 4'b1000;
                        3'b101:  dec.ls_type = 4'b1010;
                        default: dec.illegal = 1'b1;
                    endcase
                end
                OP_STORE: begin
                    dec.rs1       = in_inst[19:15];
                    dec.rs2       = in_inst[24:20];
                    dec.alu_ctrl  = ALU_ADD;
                    dec.alu_src2  = 1'b1;
                    dec.sext_type = SX_S;
                    dec.we_mem    = 1'b1;
                    case (funct3)
                        3'b000:  dec.ls_type = 4'b0001;
                        3'b001:  dec.ls_type = 4'b0011;
                        3'b010:  dec.ls_type = 4'b0101;
                        default: dec.illegal = 1'b1;
                    endcase
                end
                OP_BRANCH: begin
                    dec.rs1       = in_inst[19:15];
                    dec.rs2       = in_inst[24:20];
                    dec.alu_ctrl  = ALU_SUB;
                    dec.sext_type = SX_B;
                    dec.branch    = funct3;
                    dec.illegal   = (funct3 == 3'b010) || (funct3 == 3'b011);
                end
                OP_LUI: begin
                    dec.rd        = in_inst[11:7];
                    dec.alu_ctrl  = ALU_ADD;
                    dec.alu_src2  = 1'b1;
                    dec.sext_type = SX_U;
                    dec.we_reg    = 1'b1;
                end
                OP_AUIPC: begin
                    dec.rd        = in_inst[11:7];
                    dec.alu_ctrl  = ALU_ADD;
                    dec.alu_src1  = 1'b1;
                    dec.alu_src2  = 1'b1;
                    dec.sext_type = SX_U;
                    dec.we_reg    = 1'b1;
                end
                OP_JAL: begin
                    dec.rd        = in_inst[11:7];
                    dec.sext_type = SX_JAL;
                    dec.wb_ctrl   = 2'b11;
                    dec.jump      = 1'b1;
                    dec.jump_type = 1'b1;
                    dec.we_reg    = 1'b1;
                end
                OP_JALR: begin
                    dec.rs1       = in_inst[19:15];
                    dec.rd        = in_inst[11:7];
                    dec.alu_src2  = 1'b1;
                    dec.sext_type = SX_I;
                    dec.wb_ctrl   = 2'b11;
                    dec.jump      = 1'b1;
                    dec.we_reg    = 1'b1;
                end
                default: dec.illegal = 1'b1;
            endcase
        end
        // An undecodable word must not produce any side effect downstream
        if (dec.illegal) begin
            dec.we_reg    = 1'b0;
            dec.we_mem    = 1'b0;
            dec.jump      = 1'b0;
            dec.alu_ctrl  = ALU_NOP;
            dec.ls_type   = LS_NONE;
            dec.mul_valid = 1'b0;
            dec.mul_op    = 3'b000;
            dec.branch    = BR_NONE;
            dec.wb_ctrl   = 2'b00;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: EMPTY/ONE/TWO count the buffered instructions
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: if (accept) state_d = ST_ONE;
                ST_ONE: begin
                    if (accept && !out_ready) begin
                        state_d = ST_TWO;
                    end else if (!accept && out_ready) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_TWO:   if (out_ready) state_d = ST_ONE;
                default:  state_d = ST_EMPTY;
            endcase
        end
    end

    // FSM outputs: handshakes and datapath load enables, all decoded from state_q
    always_comb begin
        in_ready      = (state_q != ST_TWO);
        out_valid     = (state_q != ST_EMPTY);
        accept        = in_valid && in_ready;
        out_hs        = out_valid && out_ready;
        load_out_in   = !flush && accept &&
                        ((state_q == ST_EMPTY) || ((state_q == ST_ONE) && out_ready));
        load_skid     = !flush && accept && (state_q == ST_ONE) && !out_ready;
        load_out_skid = !flush && (state_q == ST_TWO) && out_ready;
    end

    // Next values of the output and skid registers
    always_comb begin
        out_d  = out_q;
        skid_d = skid_q;
        if (load_out_in) begin
            out_d = dec;
        end else if (load_out_skid) begin
            out_d = skid_q;
        end
        if (load_skid) begin
            skid_d = dec;
        end
    end

    // Output register and skid register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q  <= nop_dec();
            skid_q <= nop_dec();
        end else begin
            out_q  <= out_d;
            skid_q <= skid_d;
        end
    end

    // Next value of the delivered-instruction counter, wrapping naturally
    always_comb begin
        cnt_d = cnt_q;
        if (out_hs) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // Delivered-instruction counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign out_pc    = out_q.pc;
    assign rs1       = out_q.rs1;
    assign rs2       = out_q.rs2;
    assign rd        = out_q.rd;
    assign alu_ctrl  = out_q.alu_ctrl;
    assign branch    = out_q.branch;
    assign ls_type   = out_q.ls_type;
    assign sext_type = out_q.sext_type;
    assign wb_ctrl   = out_q.wb_ctrl;
    assign jump      = out_q.jump;
    assign jump_type = out_q.jump_type;
    assign alu_src1  = out_q.alu_src1;
    assign alu_src2  = out_q.alu_src2;
    assign we_reg    = out_q.we_reg;
    assign we_mem    = out_q.we_mem;
    assign mul_op    = out_q.mul_op;
    assign mul_valid = out_q.mul_valid;
    assign illegal   = out_q.illegal;
    assign dec_count = cnt_q;

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter EN_MEXT, default 0: 1 decodes RV32M (opcode 0110011, funct7 0000001); 0 flags those encodings illegal.
REQ-002 Parameter CNT_W, default 16: width of the decoded-instruction counter.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  in  1  reset, asynchronous and active-low.
REQ-005 flush  in  1  synchronous kill of all buffered instructions.
REQ-006 in_valid  in  1 / in_ready  out  1  upstream valid/ready handshake.
REQ-007 in_inst  in  32 / in_pc  in  32  instruction word and its PC.
REQ-008 out_valid  out  1 / out_ready  in  1  downstream valid/ready handshake.
REQ-009 out_pc  out  32  PC of the presented instruction.
REQ-010 rs1, rs2, rd  out  5 each  register indices; 0 when the format does not use the field.
REQ-011 alu_ctrl  out  4  ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLL 0101, SLT 0110, SLTU 0111, SRL 1000, SRA 1001, NOP 1110.
REQ-012 branch  out  3  funct3 of B-type; 010 (not-taken) otherwise.
REQ-013 ls_type  out  4  LB 0000, LH 0010, LW 0100, LBU 1000, LHU 1010, SB 0001, SH 0011, SW 0101, NONE 1111.
REQ-014 sext_type  out  3  I 000, B 001, JAL 010, U 011, S 110.
REQ-015 wb_ctrl  out  2  00 ALU, 01 load, 11 PC+4.
REQ-016 jump, jump_type (1=JAL, 0=JALR), alu_src1 (1=PC), alu_src2 (1=imm), we_reg, we_mem  out  1 each.
REQ-017 mul_op  out  3  M-ext funct3 when mul_valid=1, else 000; mul_valid  out  1.
REQ-018 illegal  out  1  presented instruction is undecodable.
REQ-019 dec_count  out  CNT_W  count of instructions accepted downstream.

Function
REQ-020 Decode is combinational from the input; results are registered; latency is exactly 1 cycle from input handshake to out_valid.
REQ-021 Buffering is an output register plus a 1-entry skid register; in_ready = skid empty (registered, no combinational path from out_ready).
REQ-022 FSM states: EMPTY -> ONE on input accept; ONE -> TWO on accept with out_ready=0; ONE -> EMPTY on output handshake without accept; TWO -> ONE on output handshake, skid moves to output register; ONE holds on simultaneous accept and output handshake.
REQ-023 Output fields are stable while out_valid=1 and out_ready=0.
REQ-024 flush clears both valid bits next edge (state EMPTY) and overrides a same-cycle accept; dec_count still counts a same-cycle output handshake.
REQ-025 Illegal cases: unknown opcode; R-type funct7 not 0000000/0100000 (or 0000001 when EN_MEXT=1); SUB/SRA funct7 on other funct3; I-type shift with bad funct7; load funct3 011/110/111; store funct3 > 010; branch funct3 010/011.
REQ-026 When illegal=1: we_reg=0, we_mem=0, jump=0, alu_ctrl=NOP, ls_type=NONE, mul_valid=0, branch=010.
REQ-027 All-zero instruction word decodes as NOP with illegal=0 and we_reg=0.
REQ-028 LUI forces rs1=0, alu_ctrl=ADD, alu_src2=1. AUIPC sets alu_src1=1, alu_src2=1. JAL/JALR set alu_ctrl=NOP, wb_ctrl=11.
REQ-029 M-ext instructions set mul_valid=1, we_reg=1, alu_ctrl=NOP.
REQ-030 dec_count increments on each out_valid && out_ready and wraps at 2^CNT_W-1 -> 0.

Reset
REQ-031 While rst_n=0: out_valid=0, skid empty, in_ready=1, dec_count=0, ls_type=1111, branch=010, alu_ctrl=1110, all other outputs 0.
REQ-032 Reset deasserted mid-transfer discards buffered instructions; no output handshake occurs in the first cycle after release.

Verification
REQ-033 Feed ADD x3,x1,x2 (0x002081B3) with out_ready=1 -> next cycle out_valid=1, rs1=1, rs2=2, rd=3, alu_ctrl=0000, we_reg=1, illegal=0.
REQ-034 Hold out_ready=0 and send 3 back-to-back instructions -> first two are buffered, in_ready=0 after the 2nd; releasing out_ready delivers them in order with no loss or duplication.
REQ-035 Send 0x02A50533 (MUL) with EN_MEXT=0 -> illegal=1, we_reg=0; with EN_MEXT=1 -> mul_valid=1, mul_op=000, we_reg=1.
REQ-036 Assert flush in state TWO together with in_valid=1 -> next cycle out_valid=0, in_ready=1; dec_count unchanged.
REQ-037 Use CNT_W=4 and perform 17 output handshakes -> dec_count=1.
REQ-038 Send LW funct3=011 (0x0000B083) -> illegal=1, ls_type=1111, we_reg=0.
